// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// N-channel edge detector. Each channel has:
//   - a SYNC_STAGES-deep synchroniser for an asynchronous input,
//   - a glitch filter that accepts a new level only after it has persisted
//     for STABLE_CYCLES consecutive clocks,
//   - a run-time edge mode (rising / falling / both / off),
//   - a registered one-cycle tick, and
//   - a sticky event flag with write-1-to-clear.
//
// Ports:
//   clk          in   1     system clock, rising edge
//   rst          in   1     asynchronous active-high reset
//   level        in   N     raw asynchronous input levels (bit i = channel i)
//   mode         in   2*N   per-channel mode [2i+1:2i]:
//                             00 rising, 01 falling, 10 both, 11 disabled
//   clr          in   N     write-1-to-clear for event_flags
//   tick         out  N     one-cycle pulse per qualifying filtered edge
//   filt_level   out  N     filtered (debounced) level
//   event_flags  out  N     sticky event record
//   irq          out  1     OR of event_flags
// -----------------------------------------------------------------------------
module edge_detect_multi #(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   level,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   tick,
  output logic [N-1:0]   filt_level,
  output logic [N-1:0]   event_flags,
  output logic           irq
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     sync_d [SYNC_STAGES];
  logic [N-1:0]     sync_s;
  logic [CNT_W-1:0] cnt_q  [N];
  logic [CNT_W-1:0] cnt_d  [N];
  logic [N-1:0]     filt_q, filt_d;
  logic [N-1:0]     tick_q, tick_d;
  logic [N-1:0]     flags_q, flags_d;

  // Decide whether an accepted filtered edge (towards new_level) is reported
  // under the given channel mode.
  function automatic logic edge_qualifies(input logic [1:0] m, input logic new_level);
    case (m)
      MODE_RISE: return new_level;
      MODE_FALL: return ~new_level;
      MODE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Synchroniser shift chain; stage 0 captures the raw input.
  always_comb begin
    sync_d[0] = level;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Glitch filter and edge qualification. Any cycle where the synchronised
  // level agrees with the filtered level restarts the count, so only a run of
  // STABLE_CYCLES disagreeing samples flips filt. The tick is computed on the
  // very edge that flips filt, using the mode present at that moment.
  always_comb begin
    filt_d = filt_q;
    tick_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
        tick_d[i] = edge_qualifies(mode[2*i +: 2], sync_s[i]);
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A tick being recorded outranks a simultaneous clear so no event is lost.
  always_comb begin
    flags_d = (flags_q & ~clr) | tick_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q  <= '0;
      tick_q  <= '0;
      flags_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q  <= filt_d;
      tick_q  <= tick_d;
      flags_q <= flags_d;
    end
  end

  assign tick        = tick_q;
  assign filt_level  = filt_q;
  assign event_flags = flags_q;
  assign irq         = |flags_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_multi
//
// Drives two instances sharing the same inputs: one with the default
// filtering (STABLE_CYCLES=4) and one with no filtering (STABLE_CYCLES=1).
// Both are compared every cycle against a behavioural model which keeps the
// history of sampled inputs and accepts a new filtered level when the last
// STABLE_CYCLES synchronised samples all disagree with the current one.
// -----------------------------------------------------------------------------
module tb_edge_detect_multi;

  localparam int N  = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] level = '0;
  logic [7:0] mode = '0;
  logic [3:0] clr = '0;

  logic [3:0] tick0, filt0, flags0;
  logic [3:0] tick1, filt1, flags1;
  logic       irq0, irq1;

  int errors = 0;
  int checks = 0;

  edge_detect_multi #(.N(N), .SYNC_STAGES(SS), .STABLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
    .tick(tick0), .filt_level(filt0), .event_flags(flags0), .irq(irq0)
  );

  edge_detect_multi #(.N(N), .SYNC_STAGES(SS), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
    .tick(tick1), .filt_level(filt1), .event_flags(flags1), .irq(irq1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         sc_of [2] = '{4, 1};
  logic [3:0] hist [$];
  logic [3:0] m_filt  [2];
  logic [3:0] m_tick  [2];
  logic [3:0] m_flags [2];

  // Synchronised level seen by the filter 'back' edges before the current one.
  function automatic logic [3:0] s_at(input int back);
    int idx;
    idx = hist.size() - 1 - SS - back;
    if (idx < 0) return 4'b0000;
    return hist[idx];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      m_filt[d] = '0; m_tick[d] = '0; m_flags[d] = '0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] smp;
    logic       all_diff, nl;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_back(level);
    for (int d = 0; d < 2; d++) begin
      m_flags[d] = (m_flags[d] & ~clr) | m_tick[d];
      m_tick[d]  = '0;
      for (int ch = 0; ch < N; ch++) begin
        all_diff = 1'b1;
        for (int b = 0; b < sc_of[d]; b++) begin
          smp = s_at(b);
          if (smp[ch] == m_filt[d][ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nl = ~m_filt[d][ch];
          m_filt[d][ch] = nl;
          case (mode[2*ch +: 2])
            2'b00:   m_tick[d][ch] = nl;
            2'b01:   m_tick[d][ch] = ~nl;
            2'b10:   m_tick[d][ch] = 1'b1;
            default: m_tick[d][ch] = 1'b0;
          endcase
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the posedge, outputs are compared at the negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_sc4", {tick0, filt0, flags0, irq0},
        {m_tick[0], m_filt[0], m_flags[0], |m_flags[0]});
    chk("model_sc1", {tick1, filt1, flags1, irq1},
        {m_tick[1], m_filt[1], m_flags[1], |m_flags[1]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] lvl;
    logic [3:0] clr;
    logic [3:0] tick;
    logic [3:0] filt;
    logic [3:0] flags;
    logic       irq;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int cnt, first, last, filt_seen, found;
    int hold [4];

    // Channel 0 rises (captured at row 0), tick at row 5, flag from row 6,
    // cleared at row 7, falls at row 8 and filt follows at row 13.
    for (int r = 0; r < 5; r++) tbl[r] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    for (int r = 8; r < 13; r++) tbl[r] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_state", {tick0, filt0, flags0, irq0, tick1, filt1, flags1, irq1}, 0);

    mode = 8'h00;
    for (int r = 0; r < 14; r++) begin
      level = tbl[r].lvl;
      clr   = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_tick", r),  tick0,  tbl[r].tick);
      chk($sformatf("tbl%0d_filt", r),  filt0,  tbl[r].filt);
      chk($sformatf("tbl%0d_flags", r), flags0, tbl[r].flags);
      chk($sformatf("tbl%0d_irq", r),   irq0,   tbl[r].irq);
    end
    clr = '0;

    // Glitch rejection on channel 1: 3 cycles high is dropped, 4 accepted.
    do_reset();
    for (int len = 3; len <= 4; len++) begin
      cnt = 0; filt_seen = 0;
      for (int k = 0; k < 20; k++) begin
        level = (k < len) ? 4'b0010 : 4'b0000;
        step();
        if (tick0[1]) cnt++;
        if (filt0[1]) filt_seen = 1;
      end
      chk($sformatf("glitch%0d_ticks", len), cnt, len - 3);
      chk($sformatf("glitch%0d_filt", len), filt_seen, len - 3);
    end

    // Mode sweep on channel 2 with a 10-cycle pulse.
    for (int m = 0; m < 4; m++) begin
      mode = 8'(m << 4);
      cnt = 0; first = -1; last = -1; filt_seen = 0;
      for (int k = 0; k < 30; k++) begin
        level = (k < 10) ? 4'b0100 : 4'b0000;
        step();
        if (tick0[2]) begin
          cnt++;
          if (first < 0) first = k;
          last = k;
        end
        if (filt0[2]) filt_seen = 1;
      end
      chk($sformatf("mode%0d_ticks", m), cnt, (m == 2) ? 2 : (m == 3) ? 0 : 1);
      chk($sformatf("mode%0d_filt_follows", m), filt_seen, 1);
      if (m == 2) chk("mode2_gap", last - first, 10);
    end
    mode = 8'h00;

    // Tick on channel 3 coinciding with clr[3]: flag must survive.
    do_reset();
    level = 4'b1000;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (tick0[3]) found = 1;
    end
    chk("flag_tick_seen", found, 1);
    clr = 4'b1000;
    step();
    chk("flag_set_vs_clr", flags0[3], 1'b1);
    clr = 4'b0000;
    step();
    clr = 4'b1000;
    step();
    chk("flag_cleared", flags0, 4'b0000);
    chk("irq_cleared", irq0, 1'b0);
    clr = 4'b0000;

    // Inputs held high through reset: rising edge on all channels afterwards.
    rst = 1'b1;
    level = 4'b1111;
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (tick0 != 0) cnt++;
      if (k == 5) chk("rst_rise_tick_sc4", tick0, 4'b1111);
      if (k == 2) chk("rst_rise_tick_sc1", tick1, 4'b1111);
    end
    chk("rst_rise_once", cnt, 1);

    // Asynchronous reset in the middle of a falling count.
    level = 4'b0000;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {tick0, filt0, flags0, irq0, tick1, filt1, flags1, irq1}, 0);
    model_reset();
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick0 != 0) cnt++;
    end
    chk("after_rst_no_tick", cnt, 0);

    // Unfiltered instance: simultaneous edges on all channels, both modes.
    mode = 8'hAA;
    for (int p = 0; p < 2; p++) begin
      level = (p == 0) ? 4'b1111 : 4'b0000;
      for (int k = 0; k < 4; k++) begin
        step();
        if (k == 2) chk($sformatf("sc1_simul_%0d", p), tick1, 4'b1111);
      end
    end

    // Randomized traffic: hold lengths around the filter window, random
    // modes, clears and occasional resets.
    for (int ch = 0; ch < N; ch++) hold[ch] = $urandom_range(1, 8);
    for (int it = 0; it < 2000; it++) begin
      for (int ch = 0; ch < N; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          level[ch] = ~level[ch];
          hold[ch]  = $urandom_range(1, 8);
        end
      end
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
